fetch_inst_queue: RTL and testbench
===================================

// Module: fetch_inst_queue
// PURPOSE
//  Instruction queue directly downstream of fetch stage 2. Captures up to FETCH_WIDTH
//  pre-decoded packets per cycle ({instruction, pc, targetAddr, ctiqTag, prediction}).
//  Presents up to DECODE_WIDTH packets per cycle, oldest first, to decode.
//  Decouples fetch from decode back-pressure; its full flag stalls fetch.
// PARAMETERS
//  FETCH_WIDTH   4    packets accepted per cycle
//  DECODE_WIDTH  4    packets presented per cycle
//  DEPTH         16   entries; power of two, >= FETCH_WIDTH+DECODE_WIDTH
//  PKT_W         133  packet width (SIZE_INSTRUCTION + 2*SIZE_PC + SIZE_CTI_LOG + 1)
// PORTS
//  clk            in   1                   clock
//  reset          in   1                   synchronous, active-high
//  flush_i        in   1                   discard all contents (recovery / ID redirect)
//  fs2Ready_i     in   1                   fetch bundle on inputs is valid this cycle
//  instValid_i    in   FETCH_WIDTH         per-lane valid; lane 0 oldest
//  instPacket_i   in   FETCH_WIDTH*PKT_W   lane i at [i*PKT_W +: PKT_W]
//  decodeReady_i  in   1                   decode consumes all presented valid lanes
//  instValid_o    out  DECODE_WIDTH        presented-lane valid; lane 0 oldest
//  instPacket_o   out  DECODE_WIDTH*PKT_W  presented packets
//  queueFull_o    out  1                   fetch must stall; input ignored while high
//  count_o        out  $clog2(DEPTH)+1     current occupancy
// BEHAVIOUR
//  Reset (sync, active-high): head=tail=count=0.
//   All instValid_o=0, queueFull_o=0, count_o=0 in the cycle after reset is sampled.
//  Storage: DEPTH x PKT_W circular array; head/tail are log2(DEPTH)-bit pointers.
//   Pointers wrap modulo DEPTH through natural overflow; no separate wrap bit.
//   count alone distinguishes full from empty.
//  queueFull_o = (DEPTH - count) < FETCH_WIDTH, computed from registered count only.
//   A same-cycle pop does not lower it; conservative by design.
//  Write: wr = fs2Ready_i & ~queueFull_o & ~flush_i.
//   Valid lanes are compacted in lane order; invalid lanes are skipped, holes allowed.
//   nWr = popcount(instValid_i) entries go to tail..tail+nWr-1; tail += nWr.
//  Read: instValid_o[i] = (count > i); instPacket_o lane i = entry[head+i].
//   Outputs come combinationally from registered state.
//   When decodeReady_i & ~flush_i: nRd = min(count, DECODE_WIDTH); head += nRd.
//   No partial consumption.
//  Simultaneous read+write: count_next = count + nWr - nRd. Writes never hit slots read this cycle.
//  Latency: a packet written in cycle N is visible on outputs in cycle N+1 (without bypass).
//  Flush: head=tail=count=0 next cycle. Same-cycle writes and reads are discarded.
//   Flush has priority over everything except reset.
//  Reset mid-operation behaves exactly like flush plus initial state.
//  Ordering is strict FIFO; packet contents are never modified.
// CONFIGURATION
//  FETCHQ_BYPASS_EN defined, when count==0 & wr & ~flush_i:
//   Compacted input lanes drive instValid_o/instPacket_o in the same cycle.
//   If decodeReady_i, min(nWr, DECODE_WIDTH) lanes are consumed and not stored.
//   Only the remainder is written. count, head and tail reflect the stored remainder.
//  FETCHQ_BYPASS_EN undefined: outputs depend only on registered state.
//   Minimum latency is 1 cycle.
// STRUCTURE
//  Shared package fetch_pkg: PKT_W and packet field offsets/widths
//   (INST, PC, TARGET, CTIQ_TAG, PRED) and packet typedef fetch_pkt_t.
//   Also decides the FETCH_WIDTH/DECODE_WIDTH defaults.
//  Sub-module fetchq_lane_compact: instValid_i -> per-lane write offset + popcount nWr.
//   Purely combinational. Reused by the bypass mux.
//  Top level holds the storage array, head/tail/count registers, full logic and output muxes.
// TESTING
//  1 reset, then 4 valid lanes pc=0x100,0x108,0x110,0x118 with decodeReady=0
//    -> next cycle count_o=4, instValid_o=4'b1111, lane 0 pc=0x100.
//  2 instValid_i=4'b1010 once, then decodeReady=1
//    -> count 2; lanes 0/1 hold the original lanes 1/3; after pop count 0, instValid_o=0.
//  3 fill with decodeReady=0: count reaches 13
//    -> queueFull_o=1; further input ignored; one pop of 4 -> count 9, queueFull_o=0.
//  4 wrap: 10 cycles of 4 in / 4 out
//    -> pc order strictly increasing on outputs across the pointer wrap at 16.
//  5 flush_i with count=7 and a same-cycle write+read
//    -> next cycle count_o=0, instValid_o=0, queueFull_o=0.
//  6 FETCHQ_BYPASS_EN, empty queue, 4 lanes in, decodeReady=1
//    -> same-cycle instValid_o=4'b1111; next-cycle count_o=0.
//    With the macro undefined: instValid_o=0 that cycle, count_o=4 next cycle.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-side definitions: packet layout, field offsets and default queue widths.
package fetch_pkg;

  localparam int DEF_FETCH_WIDTH  = 4;
  localparam int DEF_DECODE_WIDTH = 4;
  localparam int DEF_DEPTH        = 16;

  localparam int INST_W = 32;
  localparam int PC_W   = 48;
  localparam int CTIQ_W = 4;
  localparam int PRED_W = 1;
  localparam int PKT_W  = INST_W + 2 * PC_W + CTIQ_W + PRED_W;

  // Field LSB positions inside a flat packet, prediction bit at the bottom.
  localparam int PRED_LSB   = 0;
  localparam int CTIQ_LSB   = PRED_LSB + PRED_W;
  localparam int TARGET_LSB = CTIQ_LSB + CTIQ_W;
  localparam int PC_LSB     = TARGET_LSB + PC_W;
  localparam int INST_LSB   = PC_LSB + PC_W;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   target;
    logic [CTIQ_W-1:0] ctiq_tag;
    logic              pred;
  } fetch_pkt_t;

  function automatic logic [PC_W-1:0] pkt_pc(input logic [PKT_W-1:0] raw);
    return raw[PC_LSB +: PC_W];
  endfunction

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Fetch-to-decode handshake bundle of the instruction queue; slave = queue, master = fetch/decode side.
interface fetch_inst_queue_if
  import fetch_pkg::*;
#(
  parameter int FW    = DEF_FETCH_WIDTH,
  parameter int DW    = DEF_DECODE_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) ();

  logic                        fs2Ready_i;
  logic [FW-1:0]               instValid_i;
  logic [FW*PKT_W-1:0]         instPacket_i;
  logic                        decodeReady_i;
  logic [DW-1:0]               instValid_o;
  logic [DW*PKT_W-1:0]         instPacket_o;
  logic                        queueFull_o;
  logic [$clog2(DEPTH):0]      count_o;

  modport slave (
    input  fs2Ready_i, instValid_i, instPacket_i, decodeReady_i,
    output instValid_o, instPacket_o, queueFull_o, count_o
  );

  modport master (
    output fs2Ready_i, instValid_i, instPacket_i, decodeReady_i,
    input  instValid_o, instPacket_o, queueFull_o, count_o
  );

endinterface

// File: rtl/fetchq_lane_compact.sv
// Per-lane compaction offsets: offset_o[i] = number of valid lanes below i; count_o = popcount.
module fetchq_lane_compact #(
  parameter int LANES = 4,
  parameter int OW    = 5
) (
  input  logic [LANES-1:0]         valid_i,
  output logic [LANES-1:0][OW-1:0] offset_o,
  output logic [OW-1:0]            count_o
);

  localparam logic [OW-1:0] ONE = OW'(1);

  logic [OW-1:0] acc;

  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < LANES; i++) begin
      offset_o[i] = acc;
      if (valid_i[i]) acc = acc + ONE;
    end
    count_o = acc;
  end

endmodule

// File: rtl/fetch_inst_queue.sv
// Instruction queue between fetch stage 2 and decode: compacting multi-lane write, in-order multi-lane read.
// Optional same-cycle bypass of an empty queue when FETCHQ_BYPASS_EN is defined.
module fetch_inst_queue
  import fetch_pkg::*;
#(
  parameter int FETCH_WIDTH  = DEF_FETCH_WIDTH,
  parameter int DECODE_WIDTH = DEF_DECODE_WIDTH,
  parameter int DEPTH        = DEF_DEPTH
) (
  input logic               clk,
  input logic               reset,
  input logic               flush_i,
  fetch_inst_queue_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] FW_C    = CW'(FETCH_WIDTH);
  localparam logic [CW-1:0] DW_C    = CW'(DECODE_WIDTH);

  fetch_pkt_t mem_q [DEPTH];
  fetch_pkt_t mem_d [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [FETCH_WIDTH-1:0][CW-1:0] lane_off;
  logic [CW-1:0] n_wr, n_rd, n_byp, n_store, rel_off;
  logic [PW-1:0] waddr, raddr;
  logic          full, wr;

  fetchq_lane_compact #(
    .LANES (FETCH_WIDTH),
    .OW    (CW)
  ) u_compact (
    .valid_i  (bus.instValid_i),
    .offset_o (lane_off),
    .count_o  (n_wr)
  );

  // Full uses registered count only, so a same-cycle pop never releases fetch early.
  assign full = (DEPTH_C - count_q) < FW_C;
  assign wr   = bus.fs2Ready_i & ~full & ~flush_i;

`ifdef FETCHQ_BYPASS_EN
  logic byp_active;
  assign byp_active = wr & (count_q == '0);
  assign n_byp      = (byp_active & bus.decodeReady_i) ? ((n_wr > DW_C) ? DW_C : n_wr) : '0;
`else
  assign n_byp = '0;
`endif

  assign n_rd    = (bus.decodeReady_i & ~flush_i) ? ((count_q > DW_C) ? DW_C : count_q) : '0;
  assign n_store = wr ? (n_wr - n_byp) : '0;

  // Lanes already handed to decode by the bypass are dropped; the rest pack from tail.
  always_comb begin
    mem_d   = mem_q;
    rel_off = '0;
    waddr   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      rel_off = lane_off[i] - n_byp;
      waddr   = tail_q + rel_off[PW-1:0];
      if (wr && bus.instValid_i[i] && (lane_off[i] >= n_byp))
        mem_d[waddr] = fetch_pkt_t'(bus.instPacket_i[i*PKT_W +: PKT_W]);
    end
  end

  always_comb begin
    head_d  = head_q + n_rd[PW-1:0];
    tail_d  = tail_q + n_store[PW-1:0];
    count_d = count_q + n_store - n_rd;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    bus.instValid_o  = '0;
    bus.instPacket_o = '0;
    raddr            = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      raddr                               = head_q + PW'(i);
      bus.instValid_o[i]                  = count_q > CW'(i);
      bus.instPacket_o[i*PKT_W +: PKT_W]  = mem_q[raddr];
    end
`ifdef FETCHQ_BYPASS_EN
    if (byp_active) begin
      for (int j = 0; j < DECODE_WIDTH; j++) begin
        bus.instValid_o[j]                 = CW'(j) < n_wr;
        bus.instPacket_o[j*PKT_W +: PKT_W] = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          if (bus.instValid_i[i] && (lane_off[i] == CW'(j)))
            bus.instPacket_o[j*PKT_W +: PKT_W] = bus.instPacket_i[i*PKT_W +: PKT_W];
        end
      end
    end
`endif
  end

  assign bus.count_o     = count_q;
  assign bus.queueFull_o = full;

endmodule

// File: tb/tb_fetch_inst_queue.sv
// Self-checking bench for fetch_inst_queue: directed scenarios plus randomized traffic against a queue model.
module tb_fetch_inst_queue;
  import fetch_pkg::*;

  localparam int FW    = DEF_FETCH_WIDTH;
  localparam int DW    = DEF_DECODE_WIDTH;
  localparam int DEPTH = DEF_DEPTH;
  localparam int CW    = $clog2(DEPTH) + 1;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic flush_i;

  fetch_inst_queue_if #(.FW(FW), .DW(DW), .DEPTH(DEPTH)) bus ();

  fetch_inst_queue #(
    .FETCH_WIDTH  (FW),
    .DECODE_WIDTH (DW),
    .DEPTH        (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush_i (flush_i),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  fetch_pkt_t    in_pkt [FW];
  logic [FW-1:0] in_valid;
  logic          in_fs2, in_dready, in_flush, in_reset;
  logic [47:0]   pc_ctr = 48'h1000;

  fetch_pkt_t mq[$];
  fetch_pkt_t cin[$];
  fetch_pkt_t view[$];

  function automatic fetch_pkt_t mk_pkt(input logic [47:0] pc);
    fetch_pkt_t p;
    p.inst     = $urandom();
    p.pc       = pc;
    p.target   = 48'({$urandom(), $urandom()});
    p.ctiq_tag = 4'($urandom());
    p.pred     = 1'($urandom());
    return p;
  endfunction

  task automatic new_bundle();
    for (int i = 0; i < FW; i++) begin
      in_pkt[i] = mk_pkt(pc_ctr);
      pc_ctr    = pc_ctr + 48'd8;
    end
  endtask

  function automatic void build_cin();
    cin.delete();
    for (int i = 0; i < FW; i++)
      if (in_valid[i]) cin.push_back(in_pkt[i]);
  endfunction

  function automatic bit model_full();
    return (DEPTH - mq.size()) < FW;
  endfunction

  function automatic bit model_wr();
    return in_fs2 && !model_full() && !in_flush;
  endfunction

  // What decode should see this cycle: bypassed input if the queue is empty, else the oldest entries.
  function automatic void model_view();
    view.delete();
    build_cin();
    if (BYP && mq.size() == 0 && model_wr()) begin
      for (int k = 0; k < cin.size() && k < DW; k++) view.push_back(cin[k]);
    end else begin
      for (int k = 0; k < mq.size() && k < DW; k++) view.push_back(mq[k]);
    end
  endfunction

  function automatic void model_step();
    int skip;
    bit wr, byp;
    build_cin();
    wr   = model_wr();
    byp  = BYP && (mq.size() == 0) && wr;
    skip = 0;
    if (in_reset || in_flush) begin
      mq.delete();
      return;
    end
    if (in_dready) begin
      if (byp) skip = (cin.size() < DW) ? cin.size() : DW;
      else for (int k = 0; k < DW && mq.size() > 0; k++) void'(mq.pop_front());
    end
    if (wr) for (int k = skip; k < cin.size(); k++) mq.push_back(cin[k]);
  endfunction

  task automatic drive(input logic fs2, input logic [FW-1:0] v, input logic dr, input logic fl);
    in_fs2 = fs2; in_valid = v; in_dready = dr; in_flush = fl;
    bus.fs2Ready_i    = fs2;
    bus.instValid_i   = v;
    bus.decodeReady_i = dr;
    flush_i           = fl;
    for (int i = 0; i < FW; i++) bus.instPacket_i[i*PKT_W +: PKT_W] = in_pkt[i];
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 8 && mq.size() > 0; n++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    new_bundle();
    in_reset = 1'b1; reset = 1'b1;
    drive(1'b1, 4'b1111, 1'b1, 1'b0);
    tick(); tick();
    in_reset = 1'b0; reset = 1'b0;
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(0)) begin miscompares++; $display("FAIL reset_count got=%0d want=0", bus.count_o); end
    vectors++; if (bus.instValid_o !== 4'b0000) begin miscompares++; $display("FAIL reset_valid got=%b want=0000", bus.instValid_o); end
    vectors++; if (bus.queueFull_o !== 1'b0) begin miscompares++; $display("FAIL reset_full got=%b want=0", bus.queueFull_o); end
  endtask

  task automatic test_basic_write();
    for (int i = 0; i < FW; i++) in_pkt[i] = mk_pkt(48'h100 + 48'(8 * i));
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(4)) begin miscompares++; $display("FAIL basic_count got=%0d want=4", bus.count_o); end
    vectors++; if (bus.instValid_o !== 4'b1111) begin miscompares++; $display("FAIL basic_valid got=%b want=1111", bus.instValid_o); end
    vectors++; if (pkt_pc(bus.instPacket_o[0 +: PKT_W]) !== 48'h100) begin miscompares++; $display("FAIL basic_lane0_pc got=%h want=100", pkt_pc(bus.instPacket_o[0 +: PKT_W])); end
    vectors++; if (pkt_pc(bus.instPacket_o[3*PKT_W +: PKT_W]) !== 48'h118) begin miscompares++; $display("FAIL basic_lane3_pc got=%h want=118", pkt_pc(bus.instPacket_o[3*PKT_W +: PKT_W])); end
    drain();
  endtask

  task automatic test_holes();
    fetch_pkt_t p1, p3;
    new_bundle();
    p1 = in_pkt[1];
    p3 = in_pkt[3];
    drive(1'b1, 4'b1010, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(2)) begin miscompares++; $display("FAIL holes_count got=%0d want=2", bus.count_o); end
    vectors++; if (bus.instValid_o !== 4'b0011) begin miscompares++; $display("FAIL holes_valid got=%b want=0011", bus.instValid_o); end
    vectors++; if (fetch_pkt_t'(bus.instPacket_o[0 +: PKT_W]) !== p1) begin miscompares++; $display("FAIL holes_lane0 got=%h want=%h", bus.instPacket_o[0 +: PKT_W], p1); end
    vectors++; if (fetch_pkt_t'(bus.instPacket_o[PKT_W +: PKT_W]) !== p3) begin miscompares++; $display("FAIL holes_lane1 got=%h want=%h", bus.instPacket_o[PKT_W +: PKT_W], p3); end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(0)) begin miscompares++; $display("FAIL holes_pop_count got=%0d want=0", bus.count_o); end
    vectors++; if (bus.instValid_o !== 4'b0000) begin miscompares++; $display("FAIL holes_pop_valid got=%b want=0000", bus.instValid_o); end
  endtask

  task automatic test_full();
    for (int n = 0; n < 3; n++) begin
      new_bundle();
      drive(1'b1, 4'b1111, 1'b0, 1'b0);
      tick();
    end
    new_bundle();
    drive(1'b1, 4'b0001, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(13)) begin miscompares++; $display("FAIL full_count got=%0d want=13", bus.count_o); end
    vectors++; if (bus.queueFull_o !== 1'b1) begin miscompares++; $display("FAIL full_flag got=%b want=1", bus.queueFull_o); end
    new_bundle();
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    vectors++; if (bus.count_o !== CW'(13)) begin miscompares++; $display("FAIL full_ignored got=%0d want=13", bus.count_o); end
    for (int k = 0; k < DW; k++) begin
      vectors++;
      if (fetch_pkt_t'(bus.instPacket_o[k*PKT_W +: PKT_W]) !== mq[k]) begin
        miscompares++; $display("FAIL full_order lane%0d got=%h want=%h", k, bus.instPacket_o[k*PKT_W +: PKT_W], mq[k]);
      end
    end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(9)) begin miscompares++; $display("FAIL full_pop_count got=%0d want=9", bus.count_o); end
    vectors++; if (bus.queueFull_o !== 1'b0) begin miscompares++; $display("FAIL full_pop_flag got=%b want=0", bus.queueFull_o); end
    drain();
    vectors++; if (bus.count_o !== CW'(0)) begin miscompares++; $display("FAIL full_drain got=%0d want=0", bus.count_o); end
  endtask

  task automatic test_wrap();
    logic [47:0] last_pc;
    fetch_pkt_t  got;
    last_pc = '0;
    for (int n = 0; n < 10; n++) begin
      new_bundle();
      drive(1'b1, 4'b1111, 1'b1, 1'b0);
      model_view();
      for (int k = 0; k < DW; k++) begin
        got = fetch_pkt_t'(bus.instPacket_o[k*PKT_W +: PKT_W]);
        vectors++;
        if (bus.instValid_o[k] !== (k < view.size())) begin
          miscompares++; $display("FAIL wrap_valid cyc%0d lane%0d got=%b want=%0d", n, k, bus.instValid_o[k], k < view.size());
        end else if (k < view.size()) begin
          vectors++;
          if (got.pc <= last_pc || got !== view[k]) begin
            miscompares++; $display("FAIL wrap_order cyc%0d lane%0d got_pc=%h want_pc=%h last=%h", n, k, got.pc, view[k].pc, last_pc);
          end
          last_pc = got.pc;
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_flush();
    new_bundle();
    drive(1'b1, 4'b1111, 1'b0, 1'b0);
    tick();
    new_bundle();
    drive(1'b1, 4'b0111, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(7)) begin miscompares++; $display("FAIL flush_pre_count got=%0d want=7", bus.count_o); end
    new_bundle();
    drive(1'b1, 4'b1111, 1'b1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== CW'(0)) begin miscompares++; $display("FAIL flush_count got=%0d want=0", bus.count_o); end
    vectors++; if (bus.instValid_o !== 4'b0000) begin miscompares++; $display("FAIL flush_valid got=%b want=0000", bus.instValid_o); end
    vectors++; if (bus.queueFull_o !== 1'b0) begin miscompares++; $display("FAIL flush_full got=%b want=0", bus.queueFull_o); end
  endtask

  task automatic test_bypass();
    logic [3:0]    exp_v;
    logic [CW-1:0] exp_c;
    exp_v = BYP ? 4'b1111 : 4'b0000;
    exp_c = BYP ? CW'(0) : CW'(4);
    new_bundle();
    drive(1'b1, 4'b1111, 1'b1, 1'b0);
    vectors++; if (bus.instValid_o !== exp_v) begin miscompares++; $display("FAIL bypass_valid got=%b want=%b", bus.instValid_o, exp_v); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    vectors++; if (bus.count_o !== exp_c) begin miscompares++; $display("FAIL bypass_count got=%0d want=%0d", bus.count_o, exp_c); end
    drain();
  endtask

  task automatic test_random();
    int         dr_pct;
    logic [3:0] exp_v;
    for (int n = 0; n < 400; n++) begin
      dr_pct = ((n / 50) % 2 == 0) ? 30 : 80;
      new_bundle();
      in_reset = ($urandom_range(0, 79) == 0);
      reset    = in_reset;
      drive($urandom_range(0, 3) != 0, 4'($urandom()), $urandom_range(0, 99) < dr_pct, $urandom_range(0, 39) == 0);
      model_view();
      exp_v = '0;
      for (int k = 0; k < view.size(); k++) exp_v[k] = 1'b1;
      vectors++; if (bus.count_o !== CW'(mq.size())) begin miscompares++; $display("FAIL rand_count cyc%0d got=%0d want=%0d", n, bus.count_o, mq.size()); end
      vectors++; if (bus.queueFull_o !== model_full()) begin miscompares++; $display("FAIL rand_full cyc%0d got=%b want=%b", n, bus.queueFull_o, model_full()); end
      vectors++; if (bus.instValid_o !== exp_v) begin miscompares++; $display("FAIL rand_valid cyc%0d got=%b want=%b", n, bus.instValid_o, exp_v); end
      for (int k = 0; k < view.size(); k++) begin
        vectors++;
        if (fetch_pkt_t'(bus.instPacket_o[k*PKT_W +: PKT_W]) !== view[k]) begin
          miscompares++; $display("FAIL rand_pkt cyc%0d lane%0d got=%h want=%h", n, k, bus.instPacket_o[k*PKT_W +: PKT_W], view[k]);
        end
      end
      tick();
    end
    in_reset = 1'b0;
    reset    = 1'b0;
  endtask

  initial begin
    in_reset = 1'b0;
    reset    = 1'b0;
    test_reset();
    test_basic_write();
    test_holes();
    test_full();
    test_wrap();
    test_flush();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
